// File: rtl/icache_assoc.sv
// ---------------------------------------------------------------------------
// icache_assoc -- parametrised set-associative, read-only instruction cache.
//
// Sits between the fetch stage and the memory controller. Each block holds
// WORDS 32-bit words. Sets are 1- or 2-way with per-set LRU replacement.
// A one-cycle flush pulse invalidates every line.
//
// Parameters
//   SETS   number of sets (power of two, >= 2)
//   WAYS   associativity (1 or 2)
//   WORDS  32-bit words per block (power of two, >= 1)
//
// Ports
//   CLK        in   clock, rising edge
//   nRST       in   asynchronous active-low reset
//   imemREN    in   fetch request valid
//   imemaddr   in   fetch byte address ([1:0] ignored)
//   flush      in   invalidate all lines (one-cycle pulse)
//   ihit       out  imemload valid this cycle
//   imemload   out  instruction word (0 when not hitting)
//   iREN       out  memory read request (high for the whole fill)
//   iaddr      out  memory address of the word being filled ([1:0] = 0)
//   iwait      in   memory not ready; iload valid when iREN && !iwait
//   iload      in   memory read data
//
// Optional feature (macro ICACHE_PERF_EN)
//   hit_count  out  IDLE hit cycles, wraps at 2^32, not cleared by flush
//   miss_count out  IDLE->FILL transitions, wraps at 2^32, not cleared by flush
// ---------------------------------------------------------------------------
module icache_assoc #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        flush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int WAY_W = 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t              state;
    logic [CNT_W-1:0]    fill_cnt;
    logic [TAG_W-1:0]    fill_tag;
    logic [IDX_W-1:0]    fill_idx;
    logic [WAY_W-1:0]    fill_way;

    logic                valid_mem [WAYS][SETS];
    logic [WAY_W-1:0]    lru       [SETS];
    logic [TAG_W-1:0]    tag_mem   [WAYS][SETS];
    logic [31:0]         data_mem  [WAYS][SETS][WORDS];

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [CNT_W-1:0]    req_off;

    logic                way_hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    victim;
    logic                found_free;
    logic                lookup_hit;
    logic                word_done;

    assign req_tag = imemaddr[31 -: TAG_W];
    assign req_idx = imemaddr[2 + OFF_W +: IDX_W];
    assign req_off = CNT_W'((imemaddr >> 2) & 32'(WORDS - 1));

    // Parallel tag compare across all ways of the indexed set, plus victim
    // choice: lowest-numbered invalid way first, otherwise the LRU way.
    always_comb begin
        way_hit    = 1'b0;
        hit_way    = '0;
        victim     = lru[req_idx];
        found_free = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_mem[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
                way_hit = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!found_free && !valid_mem[w][req_idx]) begin
                victim     = WAY_W'(w);
                found_free = 1'b1;
            end
        end
    end

    assign lookup_hit = (state == IDLE) && imemREN && way_hit;
    assign word_done  = (state == FILL) && !iwait;

    assign ihit     = lookup_hit;
    assign imemload = lookup_hit ? data_mem[hit_way][req_idx][req_off] : 32'd0;
    assign iREN     = (state == FILL);
    assign iaddr    = (state == FILL)
                    ? ((32'({fill_tag, fill_idx}) << (OFF_W + 2)) | (32'(fill_cnt) << 2))
                    : 32'd0;

    // Control state: FSM, fill bookkeeping, valid and LRU bits.
    // The flush assignments come last so they override a same-cycle fill
    // completion or LRU update.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            fill_cnt <= '0;
            fill_tag <= '0;
            fill_idx <= '0;
            fill_way <= '0;
            for (int s = 0; s < SETS; s++) begin
                lru[s] <= '0;
                for (int w = 0; w < WAYS; w++) valid_mem[w][s] <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (imemREN) begin
                        if (way_hit) begin
                            if (WAYS == 2) lru[req_idx] <= ~hit_way;
                        end else begin
                            fill_tag                  <= req_tag;
                            fill_idx                  <= req_idx;
                            fill_way                  <= victim;
                            fill_cnt                  <= '0;
                            valid_mem[victim][req_idx] <= 1'b0;
                            state                     <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (!iwait) begin
                        if (fill_cnt == LAST_WORD) begin
                            valid_mem[fill_way][fill_idx] <= 1'b1;
                            if (WAYS == 2) lru[fill_idx] <= ~fill_way;
                            fill_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            fill_cnt <= fill_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (flush) begin
                for (int s = 0; s < SETS; s++) begin
                    lru[s] <= '0;
                    for (int w = 0; w < WAYS; w++) valid_mem[w][s] <= 1'b0;
                end
                if (state == FILL) begin
                    state    <= IDLE;
                    fill_cnt <= '0;
                end
            end
        end
    end

    // Line storage carries no reset; valid bits guard every read. The tag is
    // rewritten with each fill word, harmless because the line is invalid
    // for the whole fill.
    always_ff @(posedge CLK) begin
        if (word_done) begin
            data_mem[fill_way][fill_idx][fill_cnt] <= iload;
            tag_mem[fill_way][fill_idx]            <= fill_tag;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (lookup_hit) hit_count <= hit_count + 32'd1;
            if ((state == IDLE) && imemREN && !way_hit) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// ---------------------------------------------------------------------------
// tb_icache_assoc -- directed self-checking bench for icache_assoc
// (SETS=8, WAYS=2, WORDS=2: index = addr[5:3], tag = addr[31:6]).
// A small memory model answers fills after LAT wait cycles per word with a
// data pattern derived from the word address.
// ---------------------------------------------------------------------------
module tb_icache_assoc;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    localparam int LAT = 2;   // wait cycles per word before data is ready
    int            wcnt;
    logic [31:0]   acc[$];    // addresses accepted by the memory, in order
    int            fill_hits; // cycles with ihit during a fill

    icache_assoc #(.SETS(8), .WAYS(2), .WORDS(2)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .flush    (flush),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    // Memory model
    always @(posedge CLK or negedge nRST) begin
        if (!nRST)            wcnt <= 0;
        else if (!iREN)       wcnt <= 0;
        else if (wcnt == LAT) wcnt <= 0;
        else                  wcnt <= wcnt + 1;
    end
    assign iwait = iREN && (wcnt != LAT);
    assign iload = memword(iaddr);

    always @(posedge CLK) begin
        if (nRST && iREN && !iwait) acc.push_back(iaddr);
        if (nRST && iREN && ihit)   fill_hits++;
    end

    // Issue one fetch and wait (bounded) for its hit. cycles = 0 means it hit
    // on the first lookup cycle.
    task automatic fetch(input logic [31:0] a, output logic [31:0] data,
                         output int cycles, output logic iren_s, output logic to);
        @(negedge CLK);
        imemaddr = a;
        imemREN  = 1'b1;
        #1;
        iren_s = iREN;
        cycles = 0;
        while (ihit !== 1'b1 && cycles < 100) begin
            @(negedge CLK);
            #1;
            cycles++;
        end
        to   = (ihit !== 1'b1);
        data = imemload;
        @(negedge CLK);
        imemREN = 1'b0;
    endtask

    task automatic test_reset;
        nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; flush = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL reset_ihit got %b want 0", ihit); end
        n_tests++; if (imemload !== 32'd0) begin n_fail++; $display("FAIL reset_imemload got %h want 0", imemload); end
        n_tests++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL reset_iREN got %b want 0", iREN); end
        n_tests++; if (iaddr !== 32'd0) begin n_fail++; $display("FAIL reset_iaddr got %h want 0", iaddr); end
        imemREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_cold_miss;
        logic [31:0] d; int c; logic r, to;
        acc.delete(); fill_hits = 0;
        fetch(32'h40, d, c, r, to);
        // 1 lookup cycle + 2 words x (2 wait + 1 data) cycles
        n_tests++; if (to || c != 7) begin n_fail++; $display("FAIL cold_latency got %0d cycles (timeout %b) want 7", c, to); end
        n_tests++; if (d !== memword(32'h40)) begin n_fail++; $display("FAIL cold_data got %h want %h", d, memword(32'h40)); end
        n_tests++; if (acc.size() != 2 || acc[0] !== 32'h40 || acc[1] !== 32'h44) begin
            n_fail++; $display("FAIL cold_iaddr_seq got %0d words first %h want 0x40,0x44", acc.size(), (acc.size() > 0) ? acc[0] : 32'hx);
        end
        n_tests++; if (fill_hits != 0) begin n_fail++; $display("FAIL cold_ihit_in_fill got %0d want 0", fill_hits); end
    endtask

    task automatic test_block_reuse;
        logic [31:0] d; int c; logic r, to;
        fetch(32'h44, d, c, r, to);
        n_tests++; if (to || c != 0) begin n_fail++; $display("FAIL reuse_hit got %0d cycles want 0", c); end
        n_tests++; if (r !== 1'b0) begin n_fail++; $display("FAIL reuse_iREN got %b want 0", r); end
        n_tests++; if (d !== memword(32'h44)) begin n_fail++; $display("FAIL reuse_data got %h want %h", d, memword(32'h44)); end
    endtask

    task automatic test_lru_eviction;
        logic [31:0] d; int c; logic r, to;
        fetch(32'h80, d, c, r, to);   // fills the free way
        n_tests++; if (to || c == 0 || d !== memword(32'h80)) begin n_fail++; $display("FAIL lru_fill80 got %0d cycles data %h want miss data %h", c, d, memword(32'h80)); end
        fetch(32'h80, d, c, r, to);   // hit makes the 0x40 way LRU
        n_tests++; if (to || c != 0) begin n_fail++; $display("FAIL lru_hit80 got %0d cycles want 0", c); end
        fetch(32'hC0, d, c, r, to);   // evicts tag 1 (0x40)
        n_tests++; if (to || c == 0 || d !== memword(32'hC0)) begin n_fail++; $display("FAIL lru_fillC0 got %0d cycles data %h want miss data %h", c, d, memword(32'hC0)); end
        fetch(32'h84, d, c, r, to);
        n_tests++; if (to || c != 0 || d !== memword(32'h84)) begin n_fail++; $display("FAIL lru_keep80 got %0d cycles data %h want hit data %h", c, d, memword(32'h84)); end
        acc.delete();
        fetch(32'h40, d, c, r, to);
        n_tests++; if (to || c == 0 || acc.size() == 0 || acc[0] !== 32'h40) begin
            n_fail++; $display("FAIL lru_evicted40 got %0d cycles first iaddr %h want miss at 0x40", c, (acc.size() > 0) ? acc[0] : 32'hx);
        end
    endtask

    task automatic test_flush_mid_fill;
        logic [31:0] d; int c; logic r, to;
        int k;
        @(negedge CLK);
        imemaddr = 32'h100; imemREN = 1'b1;
        #1;
        k = 0;
        while (!(iREN === 1'b1 && iaddr === 32'h104) && k < 50) begin @(negedge CLK); #1; k++; end
        n_tests++; if (k >= 50) begin n_fail++; $display("FAIL flush_reach104 got timeout want iaddr 0x104"); end
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0; imemREN = 1'b0;
        #1;
        n_tests++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL flush_iREN got %b want 0", iREN); end
        acc.delete();
        fetch(32'h100, d, c, r, to);
        n_tests++; if (to || c == 0 || acc.size() == 0 || acc[0] !== 32'h100 || d !== memword(32'h100)) begin
            n_fail++; $display("FAIL flush_refill100 got %0d cycles data %h want miss data %h", c, d, memword(32'h100));
        end
        fetch(32'h80, d, c, r, to);
        n_tests++; if (to || c == 0) begin n_fail++; $display("FAIL flush_lost80 got %0d cycles want miss", c); end
    endtask

    task automatic test_flush_idle_hit;
        logic [31:0] d; int c; logic r, to;
        @(negedge CLK);
        imemaddr = 32'h80; imemREN = 1'b1; flush = 1'b1;
        #1;
        n_tests++; if (ihit !== 1'b1 || imemload !== memword(32'h80)) begin
            n_fail++; $display("FAIL flush_same_cycle_hit got ihit %b data %h want 1 %h", ihit, imemload, memword(32'h80));
        end
        @(negedge CLK);
        flush = 1'b0; imemREN = 1'b0;
        fetch(32'h80, d, c, r, to);
        n_tests++; if (to || c == 0) begin n_fail++; $display("FAIL flush_idle_invalidate got %0d cycles want miss", c); end
    endtask

    task automatic test_reset_mid_fill;
        logic [31:0] d; int c; logic r, to;
        int k;
        @(negedge CLK);
        imemaddr = 32'h200; imemREN = 1'b1;
        #1;
        k = 0;
        while (iREN !== 1'b1 && k < 20) begin @(negedge CLK); #1; k++; end
        n_tests++; if (k >= 20) begin n_fail++; $display("FAIL rstfill_start got timeout want iREN"); end
        nRST = 1'b0;
        #1;
        n_tests++; if (iREN !== 1'b0 || ihit !== 1'b0) begin n_fail++; $display("FAIL rstfill_outputs got iREN %b ihit %b want 0 0", iREN, ihit); end
        @(negedge CLK);
        nRST = 1'b1; imemREN = 1'b0;
        fetch(32'h80, d, c, r, to);
        n_tests++; if (to || c == 0) begin n_fail++; $display("FAIL rstfill_lost80 got %0d cycles want miss", c); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d; int c; logic r, to;
        fetch(32'h40, d, c, r, to);
        @(negedge CLK);
        imemaddr = 32'h40; imemREN = 1'b1;
        #1;
        n_tests++; if (ihit !== 1'b1 || imemload !== memword(32'h40)) begin n_fail++; $display("FAIL b2b_first got ihit %b data %h want 1 %h", ihit, imemload, memword(32'h40)); end
        @(negedge CLK);
        imemaddr = 32'h84;
        #1;
        n_tests++; if (ihit !== 1'b1 || imemload !== memword(32'h84) || iREN !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second got ihit %b data %h iREN %b want 1 %h 0", ihit, imemload, iREN, memword(32'h84));
        end
        @(negedge CLK);
        imemREN = 1'b0;
    endtask

`ifdef ICACHE_PERF_EN
    task automatic test_perf;
        logic [31:0] d; int c; logic r, to;
        @(negedge CLK); nRST = 1'b0;
        @(negedge CLK); nRST = 1'b1;
        // Each miss ends with one hit cycle once its fill completes.
        fetch(32'h40, d, c, r, to);
        fetch(32'h80, d, c, r, to);
        fetch(32'h44, d, c, r, to);
        n_tests++; if (miss_count !== 32'd2) begin n_fail++; $display("FAIL perf_miss got %0d want 2", miss_count); end
        n_tests++; if (hit_count !== 32'd3) begin n_fail++; $display("FAIL perf_hit got %0d want 3", hit_count); end
        @(negedge CLK); flush = 1'b1;
        @(negedge CLK); flush = 1'b0;
        #1;
        n_tests++; if (miss_count !== 32'd2 || hit_count !== 32'd3) begin n_fail++; $display("FAIL perf_flush got %0d/%0d want 2/3", miss_count, hit_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_block_reuse();
        test_lru_eviction();
        test_flush_mid_fill();
        test_flush_idle_hit();
        test_reset_mid_fill();
        test_back_to_back();
`ifdef ICACHE_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
